sop_circuit_pipe: RTL and testbench

//  Programmable, pipelined sum-of-products logic block: N_IN-bit input, N_OUT-bit output.

---
 rtl/sop_pkg.sv | 14 +
 rtl/sop_term_match.sv | 11 +
 rtl/sop_circuit_pipe.sv | 94 +++++++++
 tb/tb_sop_circuit_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared types and constants for the programmable sum-of-products pipeline.
package sop_pkg;
  localparam int SOP_N_IN    = 5;
  localparam int SOP_N_OUT   = 5;
  localparam int SOP_N_TERMS = 8;

  localparam logic CFG_TERM = 1'b0;
  localparam logic CFG_OUT  = 1'b1;

  typedef struct packed {
    logic [SOP_N_IN-1:0] care;
    logic [SOP_N_IN-1:0] val;
  } term_t;
endpackage

// File: rtl/sop_term_match.sv
// One product-term comparator: hits when every care bit of x equals its literal.
module sop_term_match #(
  parameter int N_IN = 5
) (
  input  logic [N_IN-1:0] x_i,
  input  logic [N_IN-1:0] care_i,
  input  logic [N_IN-1:0] val_i,
  output logic            hit_o
);
  assign hit_o = ~|((x_i ^ val_i) & care_i);
endmodule

// File: rtl/sop_circuit_pipe.sv
// Two-stage programmable SOP block: S1 registers term hits, S2 registers the OR-plane result.
module sop_circuit_pipe
  import sop_pkg::*;
#(
  parameter int  N_IN    = SOP_N_IN,
  parameter int  N_OUT   = SOP_N_OUT,
  parameter int  N_TERMS = SOP_N_TERMS,
  localparam int TW      = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
  localparam int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int CW      = (TW > OW) ? TW : OW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_data,
  input  logic               cfg_we,
  input  logic               cfg_kind,
  input  logic [CW-1:0]      cfg_idx,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic [N_TERMS-1:0] cfg_map,
  output logic               cfg_ready
);
  // term_t width comes from the package, so N_IN must stay at SOP_N_IN.
  term_t              terms_q [N_TERMS];
  logic [N_TERMS-1:0] map_q   [N_OUT];

  logic               s1_valid_q, s2_valid_q;
  logic [N_TERMS-1:0] hit_d, hit_q;
  logic [N_OUT-1:0]   out_d, out_q;
  logic               s1_adv, s1_en, acc, cfg_go;
  logic               term_in_rng, out_in_rng;

  assign s1_adv    = ~s2_valid_q | out_ready;
  assign s1_en     = ~s1_valid_q | s1_adv;
  assign in_ready  = ~cfg_we & s1_en;
  assign acc       = in_valid & in_ready;
  assign cfg_ready = ~s1_valid_q & ~s2_valid_q;
  assign cfg_go    = cfg_we & cfg_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = out_q;

  assign term_in_rng = ({1'b0, cfg_idx} < (CW+1)'(N_TERMS));
  assign out_in_rng  = ({1'b0, cfg_idx} < (CW+1)'(N_OUT));

  for (genvar t = 0; t < N_TERMS; t++) begin : g_term
    sop_term_match #(.N_IN(N_IN)) u_match (
      .x_i    (in_data),
      .care_i (terms_q[t].care),
      .val_i  (terms_q[t].val),
      .hit_o  (hit_d[t])
    );
  end

  always_comb begin
    out_d = '0;
    for (int o = 0; o < N_OUT; o++) out_d[o] = |(hit_q & map_q[o]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      hit_q      <= '0;
      out_q      <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= acc;
        if (acc) hit_q <= hit_d;
      end
      // out_q only moves when S2 advances, so it holds while the consumer stalls.
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) out_q <= out_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N_TERMS; t++) terms_q[t] <= '0;
      for (int o = 0; o < N_OUT; o++)   map_q[o]   <= '0;
    end else if (cfg_go) begin
      if (cfg_kind == CFG_TERM && term_in_rng)
        terms_q[cfg_idx[TW-1:0]] <= '{care: cfg_care, val: cfg_val};
      else if (cfg_kind == CFG_OUT && out_in_rng)
        map_q[cfg_idx[OW-1:0]] <= cfg_map;
    end
  end
endmodule

// File: tb/tb_sop_circuit_pipe.sv
// Directed bench for sop_circuit_pipe: reset, programming, streaming, backpressure, config stall, mid-run reset.
module tb_sop_circuit_pipe;
  import sop_pkg::*;
  localparam int N_IN = 5, N_OUT = 5, N_TERMS = 8, CW = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [N_IN-1:0]    in_data;
  logic [N_OUT-1:0]   out_data;
  logic               cfg_we, cfg_kind, cfg_ready;
  logic [CW-1:0]      cfg_idx;
  logic [N_IN-1:0]    cfg_care, cfg_val;
  logic [N_TERMS-1:0] cfg_map;

  int checks = 0, errors = 0;
  int first_acc, first_out, last_out, stall_acc;

  logic [4:0] vecs [10] = '{5'b11000, 5'b11010, 5'b00000, 5'b11111, 5'b01000,
                           5'b11001, 5'b10000, 5'b11100, 5'b00111, 5'b11011};

  sop_circuit_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_idx(cfg_idx), .cfg_care(cfg_care),
    .cfg_val(cfg_val), .cfg_map(cfg_map), .cfg_ready(cfg_ready)
  );

  always #5 clk = ~clk;

  // Expected output under the programmed configuration:
  // out4 = x4&x3&~x1 (term0), out2 = 1 (term2), out1 = x3 (term1).
  function automatic logic [4:0] exp_out(input logic [4:0] x);
    return {x[4] & x[3] & ~x[1], 1'b0, 1'b1, x[3], 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic kind, input logic [CW-1:0] idx, input logic [N_IN-1:0] care,
                        input logic [N_IN-1:0] val, input logic [N_TERMS-1:0] map);
    cfg_we = 1'b1; cfg_kind = kind; cfg_idx = idx; cfg_care = care; cfg_val = val; cfg_map = map;
    #1;
    for (int i = 0; i < 20 && !cfg_ready; i++) tick();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg_accept idx=%0d cfg_ready=%b expected 1", idx, cfg_ready);
    end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 5'b0) begin errors++; $display("FAIL rst_out_data got %b exp 00000", out_data); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready got %b exp 1", cfg_ready); end
    rst = 1'b0;
    in_valid = 1'b1; in_data = 5'b10101;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat1_out_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat2_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 5'b00000) begin errors++; $display("FAIL noconfig_out got %b exp 00000", out_data); end
    tick();
  endtask

  task automatic test_program();
    do_cfg(CFG_TERM, 3'd0, 5'b11010, 5'b11000, '0);
    do_cfg(CFG_TERM, 3'd1, 5'b01000, 5'b01000, '0);
    do_cfg(CFG_TERM, 3'd2, 5'b00000, 5'b00000, '0);
    do_cfg(CFG_OUT,  3'd4, '0, '0, 8'b001);
    do_cfg(CFG_OUT,  3'd1, '0, '0, 8'b010);
    do_cfg(CFG_OUT,  3'd2, '0, '0, 8'b100);
    do_cfg(CFG_OUT,  3'd7, '0, '0, 8'hFF);   // out of range, must be ignored
    in_valid = 1'b1; in_data = 5'b11000;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL prog_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 5'b10110) begin errors++; $display("FAIL prog_out_data got %b exp 10110", out_data); end
    tick();
  endtask

  // Stream n vectors; out_ready is low for cycles in [st_lo, st_hi).
  task automatic run_stream(input int n, input int st_lo, input int st_hi);
    int sent = 0, got = 0;
    logic ov, acc, prev_hold = 1'b0;
    logic [4:0] od, prev_od = '0;
    first_acc = -1; first_out = -1; last_out = -1; stall_acc = 0;
    for (int c = 0; c < 60 && got < n; c++) begin
      ov = out_valid; od = out_data;
      if (prev_hold && ov) begin
        checks++;
        if (od !== prev_od) begin errors++; $display("FAIL hold_stable c=%0d got %b exp %b", c, od, prev_od); end
      end
      out_ready = !(c >= st_lo && c < st_hi);
      in_valid  = (sent < n);
      in_data   = vecs[sent % 10];
      #1;
      acc = in_valid & in_ready;
      if (acc && first_acc < 0) first_acc = c;
      if (acc && !out_ready) stall_acc++;
      if (ov && out_ready) begin
        checks++;
        if (od !== exp_out(vecs[got])) begin
          errors++; $display("FAIL stream_out k=%0d got %b exp %b", got, od, exp_out(vecs[got]));
        end
        if (got == 0) first_out = c;
        last_out = c;
        got++;
      end
      prev_hold = ov & ~out_ready;
      prev_od = od;
      if (acc) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != n) begin errors++; $display("FAIL stream_count got %0d exp %0d", got, n); end
  endtask

  task automatic test_stream();
    run_stream(10, -1, -1);
    checks++;
    if (last_out - first_out != 9) begin errors++; $display("FAIL back_to_back span got %0d exp 9", last_out - first_out); end
    checks++;
    if (first_out - first_acc != 2) begin errors++; $display("FAIL stream_latency got %0d exp 2", first_out - first_acc); end
  endtask

  task automatic test_back_to_back_stall();
    run_stream(8, 0, 4);
    checks++;
    if (stall_acc != 2) begin errors++; $display("FAIL stall_accepts got %0d exp 2", stall_acc); end
  endtask

  task automatic test_cfg_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 5'b11000;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cfgst_s2_full got %b exp 1", out_valid); end
    cfg_we = 1'b1; cfg_kind = CFG_OUT; cfg_idx = 3'd0; cfg_map = 8'b100;
    in_valid = 1'b1; in_data = 5'b00000;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfgst_cfg_ready i=%0d got %b exp 0", i, cfg_ready); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cfgst_in_ready i=%0d got %b exp 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (out_data !== 5'b10110) begin errors++; $display("FAIL cfgst_held_out got %b exp 10110", out_data); end
    tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfgst_drained got %b exp 1", cfg_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cfgst_we_prio got %b exp 0", in_ready); end
    tick();
    cfg_we = 1'b0; in_data = 5'b11000;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cfgst_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 5'b10111) begin errors++; $display("FAIL cfgst_new_map got %b exp 10111", out_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 5'b11000;
    tick();
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 5'b0) begin errors++; $display("FAIL rmid_out_data got %b exp 00000", out_data); end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse got %b exp 0", out_valid); end
    in_valid = 1'b1; in_data = 5'b11000;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_after_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 5'b00000) begin errors++; $display("FAIL rmid_maps_cleared got %b exp 00000", out_data); end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_kind = 1'b0; cfg_idx = '0; cfg_care = '0; cfg_val = '0; cfg_map = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_program();
    test_stream();
    test_back_to_back_stall();
    test_cfg_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
